arr_kernel_driver: RTL and testbench
====================================

// Module: arr_kernel_driver
// PURPOSE
//  Host-side initiator for a synthesized kernel that exposes one array through a controlArr port.
//  Runs one job per request:
//   1. Streams DEPTH words into the array over the control port.
//   2. Pulses the kernel's r_enable with a start value and waits for its w_enable / result.
//   3. Reads the whole array back out as a valid/ready stream.
//  Sits between the test/host fabric and the kernel's main module.
// PARAMETERS
//  DATA_W   64    array word and result width (signed)
//  ADDR_W   1     array address width; DEPTH = 2**ADDR_W words
//  TIMEOUT  4096  max cycles in RUN before aborting with err; TIMEOUT >= 2
// PORTS
//  clk                 in   1       single clock, all logic posedge
//  rst_n               in   1       asynchronous active-low reset
//  go                  in   1       start request; sampled only in IDLE
//  go_init             in   DATA_W  start value, latched on accepted go
//  load_valid          in   1       load stream word valid
//  load_ready          out  1       load stream ready (LOAD state only)
//  load_data           in   DATA_W  word for array address = load count
//  dump_valid          out  1       readback word valid
//  dump_ready          in   1       readback consumer ready
//  dump_data           out  DATA_W  array word, ascending address
//  dump_last           out  1       high with word at address DEPTH-1
//  done                out  1       one-cycle pulse at job end
//  err                 out  1       sticky timeout flag, cleared by next accepted go
//  result_out          out  DATA_W  kernel result latched on w_enable
//  busy                out  1       high in every state except IDLE
//  r_enable            out  1       kernel start pulse
//  init_i              out  DATA_W  kernel start value (= latched go_init)
//  controlArr          out  1       1: driver owns array; 0: kernel owns array
//  controlArrWEnable_a out  1       array write enable
//  controlArrAddr_a    out  ADDR_W  array address
//  controlArrWData_a   out  DATA_W  array write data
//  controlArrRData_a   in   DATA_W  array read data, 1 cycle after address with WEnable=0
//  w_enable            in   1       kernel finished, result valid
//  result              in   DATA_W  kernel return value
// BEHAVIOUR
//  Reset values
//   - state=IDLE; controlArr=1; all other outputs 0; counters 0.
//  State machine: IDLE->LOAD->START->RUN->RD->OUT->...->DONE->IDLE.
//   - IDLE: go=1 latches go_init, clears err, addr=0, next LOAD.
//   - LOAD: load_ready=1; controlArr=1.
//     - Each load_valid&&load_ready cycle drives WEnable=1, Addr=addr, WData=load_data in that same cycle.
//     - addr++; after word DEPTH-1, addr wraps to 0 and next state is START.
//     - No handshake: WEnable=0.
//   - START (exactly 1 cycle): r_enable=1, controlArr=0, WEnable=0; next RUN with timer=0.
//   - RUN: controlArr=0, r_enable=0, timer++.
//     - w_enable=1: result_out<=result; next RD.
//     - timer==TIMEOUT-1 without w_enable: err<=1, result_out unchanged, next RD.
//   - RD: controlArr=1, WEnable=0, Addr=addr; next OUT.
//   - OUT: dump_data<=controlArrRData_a on entry; dump_valid=1; dump_last=(addr==DEPTH-1).
//     - dump_data held stable until dump_ready.
//     - On handshake: last word -> DONE; otherwise addr++ and -> RD.
//     - Throughput: 1 word per 2 cycles max.
//   - DONE (1 cycle): done=1; next IDLE.
//  Array ownership
//   - controlArr=0 only in START and RUN.
//   - controlArrWEnable_a is never 1 while controlArr=0.
//   - controlArrWEnable_a is never 1 in RD, so the read address is never invalidated.
//  Boundary rules
//   - go outside IDLE is ignored.
//   - load_valid outside LOAD is ignored.
//   - w_enable outside RUN is ignored.
//   - w_enable on the timeout cycle counts as success: err stays 0.
//   - init_i holds the latched go_init from IDLE exit until the next accepted go.
//   - Mid-job reset returns to IDLE immediately, with outputs at reset values and no done pulse.
// TESTING
//  - DEPTH=2. go, go_init=3; load 5 then 7; kernel model: w_enable after 10 cycles, result=42, array written to 9,11.
//    -> r_enable pulses once; result_out=42; dump 9 then 11, last on 11; done pulses; err=0.
//  - load_valid toggled 1,0,1 -> exactly 2 writes, at addr 0 and 1, only on handshake cycles; WEnable=0 in the gap.
//  - dump_ready held low 5 cycles -> dump_valid/dump_data stay constant; word not repeated or skipped.
//  - kernel never asserts w_enable, TIMEOUT=16 -> err=1 exactly 16 cycles after START; dump and done still occur.
//  - Next go clears err.
//  - go asserted in RUN -> ignored.
//  - rst_n low during OUT -> asynchronous return to IDLE; controlArr=1; dump_valid=0; no done.
//  - Every cycle: assert controlArr=0 implies WEnable=0.

Source files
------------

// File: rtl/arr_kernel_driver_if.sv
// Bus between the array-kernel driver and its surroundings: host load/dump
// streams, job control, and the kernel's controlArr array port.
interface arr_kernel_driver_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 1
);
  logic              go;
  logic [DATA_W-1:0] go_init;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result_out;
  logic              busy;
  logic              r_enable;
  logic [DATA_W-1:0] init_i;
  logic              controlArr;
  logic              controlArrWEnable_a;
  logic [ADDR_W-1:0] controlArrAddr_a;
  logic [DATA_W-1:0] controlArrWData_a;
  logic [DATA_W-1:0] controlArrRData_a;
  logic              w_enable;
  logic [DATA_W-1:0] result;

  // The driver is the initiator on both the host and kernel sides.
  modport master (
    input  go, go_init, load_valid, load_data, dump_ready,
           controlArrRData_a, w_enable, result,
    output load_ready, dump_valid, dump_data, dump_last, done, err,
           result_out, busy, r_enable, init_i, controlArr,
           controlArrWEnable_a, controlArrAddr_a, controlArrWData_a
  );

  modport slave (
    output go, go_init, load_valid, load_data, dump_ready,
           controlArrRData_a, w_enable, result,
    input  load_ready, dump_valid, dump_data, dump_last, done, err,
           result_out, busy, r_enable, init_i, controlArr,
           controlArrWEnable_a, controlArrAddr_a, controlArrWData_a
  );
endinterface

// File: rtl/arr_kernel_driver.sv
// Host-side job driver for a kernel with one controlArr array: load the array,
// start the kernel, wait for its result (or time out), then stream the array out.
module arr_kernel_driver #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  arr_kernel_driver_if.master bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_RD, S_OUT, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [TMR_W-1:0]  r_timer;
  logic [DATA_W-1:0] r_init;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_dump_data;
  logic              r_err;
  logic              r_held;
  logic              w_addr_last;
  logic              w_timeout;

  assign w_addr_last = (r_addr == LAST_ADDR);
  assign w_timeout   = (r_timer == TMR_LAST);

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt             = r_state;
    bus.load_ready          = 1'b0;
    bus.controlArr          = 1'b1;
    bus.controlArrWEnable_a = 1'b0;
    bus.controlArrAddr_a    = r_addr;
    bus.controlArrWData_a   = '0;
    bus.r_enable            = 1'b0;
    bus.dump_valid          = 1'b0;
    bus.dump_last           = 1'b0;
    bus.done                = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.go) w_state_nxt = S_LOAD;
      S_LOAD: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          bus.controlArrWEnable_a = 1'b1;
          bus.controlArrWData_a   = bus.load_data;
          if (w_addr_last) w_state_nxt = S_START;
        end
      end
      S_START: begin
        bus.r_enable   = 1'b1;
        bus.controlArr = 1'b0;
        w_state_nxt    = S_RUN;
      end
      S_RUN: begin
        bus.controlArr = 1'b0;
        if (bus.w_enable || w_timeout) w_state_nxt = S_RD;
      end
      S_RD: w_state_nxt = S_OUT;
      S_OUT: begin
        bus.dump_valid = 1'b1;
        bus.dump_last  = w_addr_last;
        if (bus.dump_ready) w_state_nxt = w_addr_last ? S_DONE : S_RD;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_timer     <= '0;
      r_init      <= '0;
      r_result    <= '0;
      r_dump_data <= '0;
      r_err       <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.go) begin
          r_init <= bus.go_init;
          r_err  <= 1'b0;
          r_addr <= '0;
        end
        S_LOAD:  if (bus.load_valid) r_addr <= r_addr + ADDR_W'(1);
        S_START: r_timer <= '0;
        S_RUN: begin
          r_timer <= r_timer + TMR_W'(1);
          if (bus.w_enable)   r_result <= bus.result;
          else if (w_timeout) r_err    <= 1'b1;
        end
        S_OUT: begin
          // Read data arrives during the first OUT cycle; freeze it there.
          if (!r_held) begin
            r_dump_data <= bus.controlArrRData_a;
            r_held      <= 1'b1;
          end
          if (bus.dump_ready) begin
            r_held <= 1'b0;
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dump_data  = (r_state == S_OUT && !r_held) ? bus.controlArrRData_a : r_dump_data;
  assign bus.init_i     = r_init;
  assign bus.result_out = r_result;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_arr_kernel_driver.sv
// Randomized scoreboard bench for arr_kernel_driver with a kernel/array model.
module tb_arr_kernel_driver;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 1;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t arr_t [DEPTH];
  typedef struct { word_t data; logic last; } dump_exp_t;
  typedef struct { word_t res; logic err; } done_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arr_kernel_driver_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  arr_kernel_driver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array + kernel model: driver writes through the port, kernel writes whole array.
  word_t mem [DEPTH];
  logic  k_wr;
  arr_t  k_data;
  always @(posedge clk) begin
    if (bus.controlArrWEnable_a) mem[bus.controlArrAddr_a] <= bus.controlArrWData_a;
    if (k_wr) for (int i = 0; i < DEPTH; i++) mem[i] <= k_data[i];
    if (!bus.controlArrWEnable_a) bus.controlArrRData_a <= mem[bus.controlArrAddr_a];
  end

  // Consumer: random back-pressure unless the driver asks to hold it off.
  logic hold;
  always @(posedge clk) begin
    #1;
    bus.dump_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  dump_exp_t exp_q[$];
  done_exp_t done_q[$];

  // Monitor: protocol invariants every cycle, scoreboard pops on handshakes.
  logic      pend;
  word_t     pend_data;
  logic      pend_last;
  int        ren_cnt;
  dump_exp_t de;
  done_exp_t dn;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend    = 1'b0;
      ren_cnt = 0;
    end else begin
      check("own_we", {63'b0, !bus.controlArr && bus.controlArrWEnable_a}, 64'd0);
      check("we_hs", {63'b0, bus.controlArrWEnable_a && !(bus.load_valid && bus.load_ready)}, 64'd0);
      if (bus.r_enable) ren_cnt++;
      if (pend) begin
        check("hold_valid", {63'b0, bus.dump_valid}, 64'd1);
        check("hold_data", bus.dump_data, pend_data);
        check("hold_last", {63'b0, bus.dump_last}, {63'b0, pend_last});
      end
      if (bus.dump_valid && bus.dump_ready) begin
        if (exp_q.size() == 0) check("dump_extra", 64'(bus.dump_valid), 64'd0);
        else begin
          de = exp_q.pop_front();
          check("dump_data", bus.dump_data, de.data);
          check("dump_last", {63'b0, bus.dump_last}, {63'b0, de.last});
        end
      end
      pend      = bus.dump_valid && !bus.dump_ready;
      pend_data = bus.dump_data;
      pend_last = bus.dump_last;
      if (bus.done) begin
        if (done_q.size() == 0) check("done_extra", 64'(bus.done), 64'd0);
        else begin
          dn = done_q.pop_front();
          check("result_out", bus.result_out, dn.res);
          check("err_at_done", {63'b0, bus.err}, {63'b0, dn.err});
          check("r_enable_once", 64'(ren_cnt), 64'd1);
          check("dump_complete", 64'(exp_q.size()), 64'd0);
        end
        ren_cnt = 0;
      end
    end
  end

  word_t model_result;
  logic  model_err;

  // One job. lat: RUN cycle (1..TIMEOUT) of w_enable, or -1 for a silent kernel.
  task automatic run_job(input word_t init, input arr_t ld, input int lat, input arr_t kv,
                         input word_t kres, input bit fixed_pat, input bit go_in_run,
                         input bit stall5, input bit rst_in_out);
    int    i, cyc, stop, w;
    logic  v;
    bit    ok;
    // load_valid in IDLE must be ignored; err must still hold its old value
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.load_data  = $urandom;
    check("err_sticky", {63'b0, bus.err}, {63'b0, model_err});
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.go         = 1'b1;
    bus.go_init    = init;
    @(posedge clk); #1;
    bus.go = 1'b0;
    check("err_cleared", {63'b0, bus.err}, 64'd0);
    check("init_latched", bus.init_i, init);
    model_err = 1'b0;
    i = 0; cyc = 0;
    while (i < DEPTH && cyc < 100) begin
      v = fixed_pat ? (cyc != 1) : 1'($urandom_range(0, 1));
      bus.load_valid = v;
      bus.load_data  = v ? ld[i] : word_t'($urandom);
      @(negedge clk);
      if (bus.load_valid && bus.load_ready) begin
        check("wr_en", {63'b0, bus.controlArrWEnable_a}, 64'd1);
        check("wr_addr", 64'(bus.controlArrAddr_a), 64'(i));
        check("wr_data", bus.controlArrWData_a, ld[i]);
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.load_valid = 1'b0;
    check("start_pulse", {63'b0, bus.r_enable}, 64'd1);
    ok   = (lat >= 1);
    stop = ok ? lat : TIMEOUT;
    for (int c = 1; c <= stop; c++) begin
      @(posedge clk); #1;
      bus.go      = go_in_run && (c <= 2);
      bus.go_init = ~init;
      if (c == lat) begin
        bus.w_enable = 1'b1;
        bus.result   = kres;
        k_wr = 1'b1;
        k_data = kv;
      end else begin
        bus.w_enable = 1'b0;
        bus.result   = $urandom;
        k_wr = 1'b0;
      end
      if (c == 3 && go_in_run) check("go_in_run_ignored", bus.init_i, init);
      if (c == stop) begin
        for (int k = 0; k < DEPTH; k++) exp_q.push_back('{ok ? kv[k] : ld[k], k == DEPTH - 1});
        if (ok) model_result = kres;
        model_err = !ok;
        if (!rst_in_out) done_q.push_back('{model_result, model_err});
      end
    end
    if (!ok) check("err_early", {63'b0, bus.err}, 64'd0);
    @(posedge clk); #1;
    bus.w_enable = 1'b0;
    bus.go       = 1'b0;
    k_wr         = 1'b0;
    if (!ok) begin
      check("err_timeout", {63'b0, bus.err}, 64'd1);
      bus.w_enable = 1'b1;   // outside RUN: must not touch result_out
      bus.result   = $urandom;
      @(posedge clk); #1;
      bus.w_enable = 1'b0;
    end
    if (stall5 || rst_in_out) begin
      hold = 1'b1;
      w = 0;
      while (!bus.dump_valid && w < 50) begin @(posedge clk); #1; w++; end
      check("dump_valid_seen", {63'b0, bus.dump_valid}, 64'd1);
      if (rst_in_out) begin
        #1 rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        model_result = '0;
        model_err    = 1'b0;
        #1;
        check("rst_ctl", {63'b0, bus.controlArr}, 64'd1);
        check("rst_dump_valid", {63'b0, bus.dump_valid}, 64'd0);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_result", bus.result_out, 64'd0);
        @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
      end else begin
        repeat (5) @(posedge clk);
        #1;
        check("stall_valid", {63'b0, bus.dump_valid}, 64'd1);
      end
      hold = 1'b0;
    end
    w = 0;
    while (bus.busy && w < 300) begin @(posedge clk); #1; w++; end
    check("job_end_idle", {63'b0, bus.busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 64'(done_q.size() + exp_q.size()), 64'd0);
  endtask

  function automatic arr_t rand_arr();
    arr_t a;
    for (int k = 0; k < DEPTH; k++) a[k] = {$urandom, $urandom};
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    arr_t  ld, kv;
    int    lat, r;
    rst_n = 1'b0;
    hold  = 1'b0;
    k_wr  = 1'b0;
    k_data = '{default: '0};
    bus.go = 1'b0; bus.go_init = '0; bus.load_valid = 1'b0; bus.load_data = '0;
    bus.dump_ready = 1'b0; bus.w_enable = 1'b0; bus.result = '0;
    model_result = '0;
    model_err    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl_arr", {63'b0, bus.controlArr}, 64'd1);
    check("rst_busy0", {63'b0, bus.busy}, 64'd0);
    check("rst_outputs", {58'b0, bus.load_ready, bus.dump_valid, bus.done, bus.err,
                          bus.r_enable, bus.controlArrWEnable_a}, 64'd0);
    check("rst_result0", bus.result_out, 64'd0);
    check("rst_init0", bus.init_i, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed: init 3, load 5/7 with a valid gap, kernel writes 9/11, result 42.
    run_job(64'd3, '{64'd5, 64'd7}, 10, '{64'd9, 64'd11}, 64'd42, 1'b1, 1'b0, 1'b0, 1'b0);
    // Silent kernel: timeout, go pulsed in RUN.
    run_job(64'd17, rand_arr(), -1, rand_arr(), 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Success after timeout clears err; dump held off for 5 cycles.
    run_job(64'hA5, rand_arr(), 4, rand_arr(), 64'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
    // w_enable on the timeout cycle is a success.
    run_job(64'h77, rand_arr(), TIMEOUT, rand_arr(), 64'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 24; j++) begin
      r = $urandom_range(0, 9);
      lat = (r == 0) ? -1 : (r == 1) ? TIMEOUT : $urandom_range(1, TIMEOUT - 1);
      ld = rand_arr();
      kv = rand_arr();
      run_job({$urandom, $urandom}, ld, lat, kv, {$urandom, $urandom}, 1'b0,
              (lat < 0 || lat >= 3) && ($urandom_range(0, 2) == 0),
              (lat > 0) && ($urandom_range(0, 3) == 0), 1'b0);
    end
    // Reset while a word is waiting in OUT: no done, outputs back to reset values.
    run_job(64'd9, rand_arr(), 5, rand_arr(), 64'd99, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(64'd1, rand_arr(), 2, rand_arr(), 64'd555, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
